legv8_ex_mem_reg: RTL

//  EX/MEM pipeline register for the 5-stage LEGv8 CPU. It captures the EX-stage

---
 rtl/legv8_ex_mem_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/legv8_ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage LEGv8 core: captures EX results, resolves
// the branch for MEM, supports stall/flush and emits a single redirect pulse per taken branch.
module legv8_ex_mem_reg #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_is_zero,
  input  logic [DATA_W-1:0]     ex_br_tar,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_branch,
  input  logic                  ex_branch_nz,
  input  logic                  ex_uncond,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_br_tar,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic                  mem_mem_to_reg,
  output logic                  pc_src
);

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic taken;
  } ctrl_t;

  ctrl_t                  ctrl_q, ctrl_d;
  logic [DATA_W-1:0]      alu_q, alu_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      br_tar_q, br_tar_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;
  logic                   redir_done_q, redir_done_d;
  logic                   ex_taken;
  logic                   ex_rd_xzr;
  logic                   pc_src_w;

  assign ex_taken  = ex_uncond | (ex_branch & (ex_branch_nz ? ~ex_is_zero : ex_is_zero));
  assign ex_rd_xzr = (ex_rd == {REG_ADDR_W{1'b1}});
  assign pc_src_w  = ctrl_q.valid & ctrl_q.taken & ~redir_done_q;

  always_comb begin
    ctrl_d       = ctrl_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    br_tar_d     = br_tar_q;
    rd_d         = rd_q;
    redir_done_d = redir_done_q;
    if (flush) begin
      // data fields are don't-care in a bubble, so they simply hold
      ctrl_d       = '0;
      redir_done_d = 1'b0;
    end else if (stall) begin
      // a held taken branch must not re-fire its redirect
      if (pc_src_w) redir_done_d = 1'b1;
    end else begin
      alu_d                = ex_alu_result;
      wdata_d              = ex_wdata;
      br_tar_d             = ex_br_tar;
      rd_d                 = ex_rd;
      ctrl_d.valid         = ex_valid;
      ctrl_d.mem_write     = ex_valid & ex_mem_write;
      ctrl_d.mem_read      = ex_valid & ex_mem_read & ~ex_mem_write;
      ctrl_d.reg_write     = ex_valid & ex_reg_write & ~ex_rd_xzr;
      ctrl_d.mem_to_reg    = ex_valid & ex_mem_to_reg;
      ctrl_d.taken         = ex_valid & ex_taken;
      redir_done_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      br_tar_q     <= '0;
      rd_q         <= '0;
      redir_done_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      br_tar_q     <= br_tar_d;
      rd_q         <= rd_d;
      redir_done_q <= redir_done_d;
    end
  end

  assign mem_valid      = ctrl_q.valid;
  assign mem_alu_result = alu_q;
  assign mem_wdata      = wdata_q;
  assign mem_br_tar     = br_tar_q;
  assign mem_rd         = rd_q;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_mem_write  = ctrl_q.mem_write;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_to_reg = ctrl_q.mem_to_reg;
  assign pc_src         = pc_src_w;

endmodule
